// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types, mode encodings and default widths for the FTW sweep controller.
// Revision 1.0
`default_nettype none

package sweep_pkg;

   localparam int FTW_W_DEF   = 32;
   localparam int DWELL_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } sweep_state_t;

   localparam logic [1:0] MODE_SAW_SINGLE = 2'd0;
   localparam logic [1:0] MODE_SAW_CONT   = 2'd1;
   localparam logic [1:0] MODE_TRI_SINGLE = 2'd2;
   localparam logic [1:0] MODE_TRI_CONT   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: control/config inputs and tuning-word outputs of the sweep controller.
// Revision 1.0
`default_nettype none

interface sweep_ctrl_if #(
   parameter int FTW_W   = 32,
   parameter int DWELL_W = 16
);
   logic               start;
   logic               abort;
   logic [1:0]         cfg_mode;
   logic [FTW_W-1:0]   cfg_start;
   logic [FTW_W-1:0]   cfg_stop;
   logic [FTW_W-1:0]   cfg_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [FTW_W-1:0]   ftw;
   logic               ftw_upd;
   logic               busy;
   logic               dir;
   logic               sweep_done;
   logic               cfg_err;

   modport master (
      output start, abort, cfg_mode, cfg_start, cfg_stop, cfg_step, cfg_dwell,
      input  ftw, ftw_upd, busy, dir, sweep_done, cfg_err
   );

   modport slave (
      input  start, abort, cfg_mode, cfg_start, cfg_stop, cfg_step, cfg_dwell,
      output ftw, ftw_upd, busy, dir, sweep_done, cfg_err
   );
endinterface

`default_nettype wire

// File: rtl/sweep_dwell_cnt.sv
// sweep_dwell_cnt: loadable down-counter; expire_o is high while the count sits at zero.
// Revision 1.0
`default_nettype none

module sweep_dwell_cnt #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   output logic               expire_o
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: steps a DDS tuning word between start and stop with per-value dwell.
// Revision 1.0
`default_nettype none

module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int FTW_W   = FTW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   sweep_ctrl_if.slave  bus
);

   sweep_state_t       state_q, state_d;
   logic [FTW_W-1:0]   ftw_q, ftw_d;
   logic               upd_q, upd_d;
   logic               busy_q, busy_d;
   logic               dir_q, dir_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [1:0]         mode_q, mode_d;
   logic [FTW_W-1:0]   start_q, start_d;
   logic [FTW_W-1:0]   stop_q, stop_d;
   logic [FTW_W-1:0]   step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   logic               cnt_load;
   logic [DWELL_W-1:0] cnt_val;
   logic               expire;

   // One extra bit exposes carry on the way up and borrow on the way down.
   logic [FTW_W:0]     nxt_up;
   logic [FTW_W:0]     nxt_dn;
   logic [FTW_W-1:0]   up_val;
   logic [FTW_W-1:0]   dn_val;

   sweep_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .expire_o   (expire)
   );

   always_comb begin
      nxt_up = {1'b0, ftw_q} + {1'b0, step_q};
      nxt_dn = {1'b0, ftw_q} - {1'b0, step_q};
      up_val = (nxt_up >= {1'b0, stop_q}) ? stop_q : nxt_up[FTW_W-1:0];
      dn_val = (nxt_dn[FTW_W] || (nxt_dn[FTW_W-1:0] <= start_q)) ? start_q : nxt_dn[FTW_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      ftw_d    = ftw_q;
      upd_d    = 1'b0;
      dir_d    = dir_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      mode_d   = mode_q;
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      cnt_load = 1'b0;
      cnt_val  = dwell_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               mode_d  = bus.cfg_mode;
               start_d = bus.cfg_start;
               stop_d  = bus.cfg_stop;
               step_d  = bus.cfg_step;
               dwell_d = bus.cfg_dwell;
               if ((bus.cfg_step == '0) || (bus.cfg_start > bus.cfg_stop)) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = ST_UP;
                  ftw_d    = bus.cfg_start;
                  upd_d    = 1'b1;
                  dir_d    = 1'b0;
                  cnt_load = 1'b1;
                  cnt_val  = bus.cfg_dwell;
               end
            end
         end

         ST_UP: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               dir_d   = 1'b0;
            end else if (expire) begin
               cnt_load = 1'b1;
               if (ftw_q == stop_q) begin
                  case (mode_q)
                     MODE_SAW_SINGLE: begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        cnt_load = 1'b0;
                     end
                     MODE_SAW_CONT: begin
                        ftw_d = start_q;
                        upd_d = (start_q != ftw_q);
                     end
                     default: begin
                        state_d = ST_DOWN;
                        dir_d   = 1'b1;
                        ftw_d   = dn_val;
                        upd_d   = (dn_val != ftw_q);
                     end
                  endcase
               end else begin
                  ftw_d = up_val;
                  upd_d = (up_val != ftw_q);
               end
            end
         end

         ST_DOWN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               dir_d   = 1'b0;
            end else if (expire) begin
               cnt_load = 1'b1;
               if (ftw_q == start_q) begin
                  if (mode_q == MODE_TRI_CONT) begin
                     state_d = ST_UP;
                     dir_d   = 1'b0;
                     ftw_d   = up_val;
                     upd_d   = (up_val != ftw_q);
                  end else begin
                     state_d  = ST_IDLE;
                     dir_d    = 1'b0;
                     done_d   = 1'b1;
                     cnt_load = 1'b0;
                  end
               end else begin
                  ftw_d = dn_val;
                  upd_d = (dn_val != ftw_q);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            dir_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         ftw_q   <= '0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= '0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         ftw_q   <= ftw_d;
         upd_q   <= upd_d;
         busy_q  <= busy_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
      end
   end

   assign bus.ftw        = ftw_q;
   assign bus.ftw_upd    = upd_q;
   assign bus.busy       = busy_q;
   assign bus.dir        = dir_q;
   assign bus.sweep_done = done_q;
   assign bus.cfg_err    = err_q;

endmodule

`default_nettype wire
